// File: rtl/ej7_bist_pkg.sv
// Shared types, default widths and helpers for the ej7 BIST slice.
package ej7_bist_pkg;

  localparam int unsigned K_DEF      = 4;
  localparam int unsigned K2_DEF     = 3;
  localparam int unsigned NPAIR_DEF  = 3;
  localparam int unsigned SETTLE_DEF = 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ej7_vec_gen.sv
// Stimulus vector counter plus per-vector settle down-counter.
module ej7_vec_gen
  import ej7_bist_pkg::*;
#(
  parameter int unsigned K      = K_DEF,
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         settle_load,
  output logic [K-1:0] vec,
  output logic         last_c,
  output logic         expired_c
);

  localparam int unsigned SW = cnt_width(SETTLE);

  logic [SW-1:0] settle_cnt;

  assign last_c    = (vec == {K{1'b1}});
  assign expired_c = (settle_cnt == '0);

  // Vector counter never wraps; it holds at the last vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec <= '0;
    end else if (clr) begin
      vec <= '0;
    end else if (inc && !last_c) begin
      vec <= vec + K'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      settle_cnt <= '0;
    end else if (settle_load) begin
      settle_cnt <= SW'(SETTLE - 1);
    end else if (!expired_c) begin
      settle_cnt <= settle_cnt - SW'(1);
    end
  end

endmodule

// File: rtl/ej7_bist.sv
// Exhaustive stimulus generator and pairwise response checker for ej7.
module ej7_bist
  import ej7_bist_pkg::*;
#(
  parameter int unsigned K      = K_DEF,
  parameter int unsigned K2     = K2_DEF,
  parameter int unsigned NPAIR  = NPAIR_DEF,
  parameter int unsigned SETTLE = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [K-1:0]     vec,
  output logic [K2-1:0]    vec2,
  input  logic [NPAIR-1:0] resp_a,
  input  logic [NPAIR-1:0] resp_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [K:0]       err_count,
  output logic [K-1:0]     fail_vec,
  output logic [NPAIR-1:0] fail_mask
);

  localparam logic [K:0] ERR_MAX = (K+1)'(2**K);
  localparam logic [K:0] LIM2    = (K+1)'(2**K2);

  state_t state, state_nx;

  logic             start_ok_c;
  logic             clr_c;
  logic             inc_c;
  logic             settle_load_c;
  logic             sample_c;
  logic             last_c;
  logic             expired_c;
  logic [NPAIR-1:0] en_c;
  logic [NPAIR-1:0] mm_c;

  ej7_vec_gen #(
    .K      (K),
    .SETTLE (SETTLE)
  ) u_vec_gen (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr_c),
    .inc         (inc_c),
    .settle_load (settle_load_c),
    .vec         (vec),
    .last_c      (last_c),
    .expired_c   (expired_c)
  );

  assign vec2       = vec[K2-1:0];
  assign start_ok_c = start && !busy;

  // The circuit-2 pair only has meaning while vec fits in K2 bits.
  always_comb begin
    en_c            = '1;
    en_c[NPAIR-1]   = ({1'b0, vec} < LIM2);
    mm_c            = (resp_a ^ resp_b) & en_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start_ok_c) state_nx = S_SETTLE;
      S_SETTLE: if (expired_c)  state_nx = S_SAMPLE;
      S_SAMPLE: state_nx = last_c ? S_DONE : S_SETTLE;
      S_DONE:   if (start_ok_c) state_nx = S_SETTLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    clr_c         = 1'b0;
    inc_c         = 1'b0;
    sample_c      = 1'b0;
    settle_load_c = (state_nx == S_SETTLE) && (state != S_SETTLE);
    case (state)
      S_IDLE, S_DONE: clr_c = start_ok_c;
      S_SAMPLE: begin
        inc_c    = 1'b1;
        sample_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Result registers; status flags settle one cycle after DONE is entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
      fail_mask <= '0;
    end else if (clr_c) begin
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
      fail_mask <= '0;
    end else begin
      if (sample_c && (mm_c != '0)) begin
        if (err_count != ERR_MAX) begin
          err_count <= err_count + (K+1)'(1);
        end
        if (err_count == '0) begin
          fail_vec  <= vec;
          fail_mask <= mm_c;
        end
      end
      if ((state == S_DONE) && busy) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_count == '0);
      end
    end
  end

endmodule

// File: tb/tb_ej7_bist.sv
// Directed self-checking bench for ej7_bist with a behavioural ej7 stand-in.
module tb_ej7_bist;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] vec;
  logic [2:0] vec2;
  logic [2:0] resp_a;
  logic [2:0] resp_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic [3:0] fail_vec;
  logic [2:0] fail_mask;

  int total = 0;
  int bad   = 0;
  int mode  = 0;

  ej7_bist dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .vec       (vec),
    .vec2      (vec2),
    .resp_a    (resp_a),
    .resp_b    (resp_b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec),
    .fail_mask (fail_mask)
  );

  always #5 clk = ~clk;

  // Golden stand-in for ej7 plus injectable faults on the alternate outputs.
  always_comb begin
    logic [2:0] flt;
    resp_a = {^vec2, vec[3] & vec[0], vec[1] | vec[2]};
    flt = 3'b000;
    case (mode)
      1: if (vec == 4'd5) flt = 3'b001;
      2: if (vec >= 4'd8) flt = 3'b100;
      3: if (vec == 4'd3) flt = 3'b100;
      4: flt = 3'b111;
      default: flt = 3'b000;
    endcase
    resp_b = resp_a ^ flt;
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int vec_bad);
    int ev;
    n = 0;
    vec_bad = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      ev = (n / 2 > 15) ? 15 : n / 2;
      if (vec !== 4'(ev)) vec_bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    total++;
    if ({vec, vec2, busy, done, pass, err_count, fail_vec, fail_mask} !== 23'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {vec, vec2, busy, done, pass, err_count, fail_vec, fail_mask});
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || vec !== 4'd0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b vec=%0d want busy=0 vec=0", busy, vec);
    end
  endtask

  task automatic test_golden();
    int n, vb;
    mode = 0;
    pulse_start();
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || vec !== 4'd0) begin
      bad++;
      $display("FAIL golden_start: busy=%b done=%b vec=%0d want 1 0 0", busy, done, vec);
    end
    wait_done(n, vb);
    total++;
    if (n !== 33) begin
      bad++;
      $display("FAIL golden_latency: got %0d want 33", n);
    end
    total++;
    if (vb !== 0) begin
      bad++;
      $display("FAIL golden_vec_seq: got %0d wrong cycles want 0", vb);
    end
    total++;
    if (pass !== 1'b1 || err_count !== 5'd0 || fail_vec !== 4'd0 || fail_mask !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL golden_result: pass=%b err=%0d fv=%0d fm=%b busy=%b want 1 0 0 000 0",
               pass, err_count, fail_vec, fail_mask, busy);
    end
    total++;
    if (vec !== 4'd15 || vec2 !== 3'd7) begin
      bad++;
      $display("FAIL golden_vec_hold: vec=%0d vec2=%0d want 15 7", vec, vec2);
    end
  endtask

  task automatic run_fault(input int m, input string nm, input logic [4:0] e_err,
                           input logic [3:0] e_fv, input logic [2:0] e_fm, input logic e_pass);
    int n, vb;
    mode = m;
    pulse_start();
    wait_done(n, vb);
    total++;
    if (n !== 33 || err_count !== e_err || fail_vec !== e_fv || fail_mask !== e_fm || pass !== e_pass) begin
      bad++;
      $display("FAIL %s: n=%0d err=%0d fv=%0d fm=%b pass=%b want n=33 err=%0d fv=%0d fm=%b pass=%b",
               nm, n, err_count, fail_vec, fail_mask, pass, e_err, e_fv, e_fm, e_pass);
    end
  endtask

  task automatic test_faults();
    run_fault(1, "fault_y_at5",    5'd1,  4'd5, 3'b001, 1'b0);
    run_fault(2, "fault_f2_masked", 5'd0,  4'd0, 3'b000, 1'b1);
    run_fault(3, "fault_f2_at3",   5'd1,  4'd3, 3'b100, 1'b0);
    run_fault(4, "fault_all",      5'd16, 4'd0, 3'b111, 1'b0);
  endtask

  task automatic test_mid_reset();
    int n, vb, guard;
    mode = 1;
    pulse_start();
    guard = 0;
    while (vec !== 4'd7 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    total++;
    if (vec !== 4'd7) begin
      bad++;
      $display("FAIL midreset_reach7: vec=%0d want 7", vec);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({vec, vec2, busy, done, pass, err_count, fail_vec, fail_mask} !== 23'd0) begin
      bad++;
      $display("FAIL midreset_outputs: got %h want 0",
               {vec, vec2, busy, done, pass, err_count, fail_vec, fail_mask});
    end
    @(negedge clk);
    reset = 1'b1;
    mode = 0;
    pulse_start();
    total++;
    if (vec !== 4'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midreset_restart: vec=%0d busy=%b want 0 1", vec, busy);
    end
    wait_done(n, vb);
    total++;
    if (n !== 33 || vb !== 0 || pass !== 1'b1) begin
      bad++;
      $display("FAIL midreset_sweep: n=%0d vecbad=%0d pass=%b want 33 0 1", n, vb, pass);
    end
  endtask

  task automatic test_start_busy();
    int n;
    mode = 0;
    pulse_start();
    n = 0;
    while (!done && n < 200) begin
      if (n == 10 || n == 32) begin
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
      n++;
    end
    total++;
    if (n !== 33 || pass !== 1'b1) begin
      bad++;
      $display("FAIL start_busy_ignored: n=%0d pass=%b want 33 1", n, pass);
    end
  endtask

  task automatic test_restart();
    int n, vb;
    mode = 4;
    pulse_start();
    wait_done(n, vb);
    mode = 1;
    pulse_start();
    total++;
    if (done !== 1'b0 || pass !== 1'b0 || err_count !== 5'd0 || busy !== 1'b1 || vec !== 4'd0) begin
      bad++;
      $display("FAIL restart_clear: done=%b pass=%b err=%0d busy=%b vec=%0d want 0 0 0 1 0",
               done, pass, err_count, busy, vec);
    end
    wait_done(n, vb);
    total++;
    if (n !== 33 || err_count !== 5'd1 || fail_vec !== 4'd5 || fail_mask !== 3'b001) begin
      bad++;
      $display("FAIL restart_sweep: n=%0d err=%0d fv=%0d fm=%b want 33 1 5 001",
               n, err_count, fail_vec, fail_mask);
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_faults();
    test_mid_reset();
    test_start_busy();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
